pq_lsb: RTL and testbench

- Parameterized LSB-first priority arbiter, used as a generic grant picker (issue-queue/LSQ select, free-list pick).
- Picks the lowest-index asserted request and drives a one-hot ack for it.
- Also drives a thermometer mask covering the winner and every higher index.
- Combinational outputs serve same-cycle consumers; registered copies serve next-cycle consumers.

---
 rtl/pq_lsb.sv | 79 +++++++
 tb/tb_pq_lsb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pq_lsb.sv
// LSB-first priority arbiter: one-hot grant, thermometer mask and valid, plus one-cycle registered copies.
// Optional concurrent self-checks are compiled in when PQ_LSB_ASSERT_EN is defined.
module pq_lsb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] req_vec,
  output logic [WIDTH-1:0] ack_one_hot,
  output logic [WIDTH-1:0] ack_mask,
  output logic             ack_valid,
  output logic [WIDTH-1:0] ack_one_hot_q,
  output logic [WIDTH-1:0] ack_mask_q,
  output logic             ack_valid_q
);

  logic [WIDTH-1:0] w_one_hot;
  logic [WIDTH-1:0] w_mask;
  logic             w_valid;

  logic [WIDTH-1:0] r_one_hot;
  logic [WIDTH-1:0] r_mask;
  logic             r_valid;

  // Isolate the lowest set bit. With no request, one_hot is 0 and ~(0 - 1) is 0,
  // so the mask cannot wrap to all-ones.
  always_comb begin
    w_one_hot = req_vec & (~req_vec + WIDTH'(1));
    w_mask    = ~(w_one_hot - WIDTH'(1));
    w_valid   = |req_vec;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_one_hot <= '0;
      r_mask    <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_one_hot <= w_one_hot;
      r_mask    <= w_mask;
      r_valid   <= w_valid;
    end
  end

  assign ack_one_hot   = w_one_hot;
  assign ack_mask      = w_mask;
  assign ack_valid     = w_valid;
  assign ack_one_hot_q = r_one_hot;
  assign ack_mask_q    = r_mask;
  assign ack_valid_q   = r_valid;

`ifdef PQ_LSB_ASSERT_EN
  a_onehot0 : assert property (@(posedge CLK) disable iff (!nRST)
    $onehot0(ack_one_hot))
    else $error("pq_lsb: ack_one_hot not onehot0 req=%h oh=%h", req_vec, ack_one_hot);

  a_subset : assert property (@(posedge CLK) disable iff (!nRST)
    (ack_one_hot & ~req_vec) == '0)
    else $error("pq_lsb: grant outside request req=%h oh=%h", req_vec, ack_one_hot);

  a_valid : assert property (@(posedge CLK) disable iff (!nRST)
    ack_valid == (|req_vec))
    else $error("pq_lsb: valid mismatch req=%h valid=%b", req_vec, ack_valid);

  a_mask : assert property (@(posedge CLK) disable iff (!nRST)
    (ack_mask == ~(ack_one_hot - WIDTH'(1))) &&
    (ack_one_hot == (ack_mask & ~(ack_mask << 1))))
    else $error("pq_lsb: mask invariant req=%h oh=%h mask=%h", req_vec, ack_one_hot, ack_mask);

  // The first edge after reset release compares against values sampled while in reset.
  a_lag : assert property (@(posedge CLK) disable iff (!nRST)
    $past(nRST) |-> (ack_one_hot_q == $past(ack_one_hot)) &&
                    (ack_mask_q == $past(ack_mask)) &&
                    (ack_valid_q == $past(ack_valid)))
    else $error("pq_lsb: registered lag oh_q=%h mask_q=%h valid_q=%b",
                ack_one_hot_q, ack_mask_q, ack_valid_q);
`endif

endmodule

// File: tb/tb_pq_lsb.sv
// Self-checking bench for pq_lsb at WIDTH 8, 1, 3 and 16 against a lowest-index-search model.
module tb_pq_lsb;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0]  r8,  oh8,  m8,  oh8q,  m8q;
  logic        v8,  v8q;
  logic [0:0]  r1,  oh1,  m1,  oh1q,  m1q;
  logic        v1,  v1q;
  logic [2:0]  r3,  oh3,  m3,  oh3q,  m3q;
  logic        v3,  v3q;
  logic [15:0] r16, oh16, m16, oh16q, m16q;
  logic        v16, v16q;

  pq_lsb #(.WIDTH(8)) u_w8 (.CLK(CLK), .nRST(nRST), .req_vec(r8), .ack_one_hot(oh8),
    .ack_mask(m8), .ack_valid(v8), .ack_one_hot_q(oh8q), .ack_mask_q(m8q), .ack_valid_q(v8q));
  pq_lsb #(.WIDTH(1)) u_w1 (.CLK(CLK), .nRST(nRST), .req_vec(r1), .ack_one_hot(oh1),
    .ack_mask(m1), .ack_valid(v1), .ack_one_hot_q(oh1q), .ack_mask_q(m1q), .ack_valid_q(v1q));
  pq_lsb #(.WIDTH(3)) u_w3 (.CLK(CLK), .nRST(nRST), .req_vec(r3), .ack_one_hot(oh3),
    .ack_mask(m3), .ack_valid(v3), .ack_one_hot_q(oh3q), .ack_mask_q(m3q), .ack_valid_q(v3q));
  pq_lsb #(.WIDTH(16)) u_w16 (.CLK(CLK), .nRST(nRST), .req_vec(r16), .ack_one_hot(oh16),
    .ack_mask(m16), .ack_valid(v16), .ack_one_hot_q(oh16q), .ack_mask_q(m16q), .ack_valid_q(v16q));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] oh;
    logic [7:0] mask;
    logic       valid;
  } vec_t;

  // Reference: scan upward for the first request; mask covers that index to the top.
  function automatic void ref_pick(input int w, input logic [15:0] r,
                                   output logic [15:0] oh, output logic [15:0] m,
                                   output logic v);
    oh = '0;
    m  = '0;
    v  = 1'b0;
    for (int j = 0; j < w; j++) begin
      if (r[j]) begin
        oh[j] = 1'b1;
        v     = 1'b1;
        for (int k = j; k < w; k++) m[k] = 1'b1;
        break;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_comb(input int w, input logic [15:0] r, input logic [15:0] oh,
                          input logic [15:0] m, input logic v, input string tag);
    logic [15:0] eoh, em;
    logic        ev;
    ref_pick(w, r, eoh, em, ev);
    chk({tag, " oh"}, oh, eoh);
    chk({tag, " mask"}, m, em);
    chk({tag, " valid"}, 16'(v), 16'(ev));
  endtask

  task automatic chk_q(input int w, input logic [15:0] r, input logic [15:0] ohq,
                       input logic [15:0] mq, input logic vq, input string tag);
    logic [15:0] eoh, em;
    logic        ev;
    ref_pick(w, r, eoh, em, ev);
    chk({tag, " oh_q"}, ohq, eoh);
    chk({tag, " mask_q"}, mq, em);
    chk({tag, " valid_q"}, 16'(vq), 16'(ev));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    logic [7:0] prev8;
    logic [0:0] p1;
    logic [2:0] p3;
    logic [15:0] p16;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{8'h2C, 8'h04, 8'hFC, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 8'h80, 1'b1};
    tbl[3] = '{8'hFF, 8'h01, 8'hFF, 1'b1};
    tbl[4] = '{8'h01, 8'h01, 8'hFF, 1'b1};
    tbl[5] = '{8'h50, 8'h10, 8'hF0, 1'b1};

    r8 = '0; r1 = '0; r3 = '0; r16 = '0;

    // Reset state, and _q held at 0 across edges while in reset
    #3;
    chk("rst oh", 16'(oh8), 16'h0);
    chk("rst mask", 16'(m8), 16'h0);
    chk("rst oh_q", 16'(oh8q), 16'h0);
    chk("rst mask_q", 16'(m8q), 16'h0);
    chk("rst valid_q", 16'(v8q), 16'h0);
    @(negedge CLK);
    r8 = 8'h2C;
    #1 chk_comb(8, 16'(r8), 16'(oh8), 16'(m8), v8, "in-reset comb");
    @(negedge CLK);
    chk("in-reset oh_q", 16'(oh8q), 16'h0);
    chk("in-reset mask_q", 16'(m8q), 16'h0);
    r8 = 8'h00;
    nRST = 1'b1;
    #1;
    chk("release oh", 16'(oh8), 16'h0);
    chk("release oh_q", 16'(oh8q), 16'h0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      r8 = tbl[i].req;
      #1;
      chk($sformatf("tbl%0d oh", i), 16'(oh8), 16'(tbl[i].oh));
      chk($sformatf("tbl%0d mask", i), 16'(m8), 16'(tbl[i].mask));
      chk($sformatf("tbl%0d valid", i), 16'(v8), 16'(tbl[i].valid));
    end

    // Exhaustive WIDTH=8 with one-cycle lag check on the previous value
    prev8 = r8;
    for (int i = 0; i < 256; i++) begin
      @(negedge CLK);
      chk_q(8, 16'(prev8), 16'(oh8q), 16'(m8q), v8q, $sformatf("exh%0d", i));
      r8 = 8'(i);
      #1 chk_comb(8, 16'(r8), 16'(oh8), 16'(m8), v8, $sformatf("exh%0d", i));
      prev8 = r8;
    end

    // Registered lag sequence
    @(negedge CLK);
    r8 = 8'h10;
    @(negedge CLK);
    chk("lag1 oh_q", 16'(oh8q), 16'h0010);
    chk("lag1 mask_q", 16'(m8q), 16'h00F0);
    r8 = 8'h02;
    @(negedge CLK);
    chk("lag2 oh_q", 16'(oh8q), 16'h0002);
    chk("lag2 mask_q", 16'(m8q), 16'h00FE);

    // Async reset between edges clears _q at once; comb keeps tracking
    #2 nRST = 1'b0;
    #1;
    chk("async oh_q", 16'(oh8q), 16'h0);
    chk("async mask_q", 16'(m8q), 16'h0);
    chk("async valid_q", 16'(v8q), 16'h0);
    chk_comb(8, 16'(r8), 16'(oh8), 16'(m8), v8, "async comb");
    r8 = 8'h60;
    #1 chk_comb(8, 16'(r8), 16'(oh8), 16'(m8), v8, "async comb2");
    @(negedge CLK);
    chk("async held oh_q", 16'(oh8q), 16'h0);
    nRST = 1'b1;
    r8 = 8'h08;
    @(negedge CLK);
    chk("post-rst oh_q", 16'(oh8q), 16'h0008);
    chk("post-rst mask_q", 16'(m8q), 16'h00F8);

    // Zero request on every width: mask must stay zero
    r1 = '0; r3 = '0; r16 = '0; r8 = '0;
    #1;
    chk("zero w1 mask", 16'(m1), 16'h0);
    chk("zero w3 mask", 16'(m3), 16'h0);
    chk("zero w16 mask", m16, 16'h0);
    chk("zero w8 mask", 16'(m8), 16'h0);

    // Edge cases on WIDTH 16 and WIDTH 1
    @(negedge CLK);
    r16 = 16'h8000; r1 = 1'b1;
    #1;
    chk("w16 top oh", oh16, 16'h8000);
    chk("w16 top mask", m16, 16'h8000);
    chk("w1 oh", 16'(oh1), 16'h1);
    chk("w1 mask", 16'(m1), 16'h1);

    // Random sweep on widths 1, 3, 16, 8 with lag checks
    p1 = r1; p3 = r3; p16 = r16; prev8 = r8;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      chk_q(1, 16'(p1), 16'(oh1q), 16'(m1q), v1q, $sformatf("rnd%0d w1", i));
      chk_q(3, 16'(p3), 16'(oh3q), 16'(m3q), v3q, $sformatf("rnd%0d w3", i));
      chk_q(16, p16, oh16q, m16q, v16q, $sformatf("rnd%0d w16", i));
      chk_q(8, 16'(prev8), 16'(oh8q), 16'(m8q), v8q, $sformatf("rnd%0d w8", i));
      r1  = 1'($urandom);
      r3  = 3'($urandom);
      // Sparse patterns reach high winners on the wide instance
      r16 = (i % 4 == 0) ? 16'(16'h1 << $urandom_range(15, 0)) : 16'($urandom);
      r8  = (i % 8 == 0) ? 8'h00 : 8'($urandom);
      #1;
      chk_comb(1, 16'(r1), 16'(oh1), 16'(m1), v1, $sformatf("rnd%0d w1", i));
      chk_comb(3, 16'(r3), 16'(oh3), 16'(m3), v3, $sformatf("rnd%0d w3", i));
      chk_comb(16, r16, oh16, m16, v16, $sformatf("rnd%0d w16", i));
      chk_comb(8, 16'(r8), 16'(oh8), 16'(m8), v8, $sformatf("rnd%0d w8", i));
      p1 = r1; p3 = r3; p16 = r16; prev8 = r8;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
